// File: rtl/shift_pkg.sv
// Shared types and constants for the parallel-in, serial-out transmitter.
// Holds the FSM state enum, the default word width and the bit-counter width helper.
package shift_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

    // Bits needed to count 0..width-1; callers guarantee width >= 2.
    function automatic int cnt_width(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/shift_serializer_tx_if.sv
// Word-load handshake between a producer and the serial transmitter.
// The producer drives valid/data; the transmitter answers with ready.
interface shift_serializer_tx_if
    import shift_pkg::*;
    #(parameter int WIDTH = DEFAULT_WIDTH);

    logic             load_valid;
    logic [WIDTH-1:0] load_data;
    logic             load_ready;

    modport master (
        output load_valid,
        output load_data,
        input  load_ready
    );

    modport slave (
        input  load_valid,
        input  load_data,
        output load_ready
    );

endinterface

// File: rtl/ser_hold_buf.sv
// One-entry holding register that lets the next word wait while the current one shifts.
// A write fills it, a read empties it; the parent never issues both on the same edge.
module ser_hold_buf
    import shift_pkg::*;
    #(parameter int WIDTH = DEFAULT_WIDTH)
(
    input  logic             clk,
    input  logic             rst,
    input  logic             wr,
    input  logic             rd,
    input  logic [WIDTH-1:0] data,
    output logic             full,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            full <= 1'b0;
            q    <= '0;
        end else if (wr) begin
            full <= 1'b1;
            q    <= data;
        end else if (rd) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/shift_serializer_tx.sv
// Parallel-in, serial-out transmitter: shifts a WIDTH-bit word out one bit per en tick.
// A holding buffer queues the next word so back-to-back frames leave no gap bits.
module shift_serializer_tx
    import shift_pkg::*;
    #(
        parameter int WIDTH     = DEFAULT_WIDTH,
        parameter bit MSB_FIRST = 1'b1
    )
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    shift_serializer_tx_if.slave  load,
    output logic                  sout,
    output logic                  sout_bar,
    output logic                  frame,
    output logic                  done
);

    localparam int            CW   = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             done_q, done_d;
    logic             buf_full, buf_wr, buf_rd;
    logic [WIDTH-1:0] buf_q;
    logic             accept;
    logic [WIDTH-1:0] shreg_adv;

    ser_hold_buf #(.WIDTH(WIDTH)) u_hold (
        .clk  (clk),
        .rst  (rst),
        .wr   (buf_wr),
        .rd   (buf_rd),
        .data (load.load_data),
        .full (buf_full),
        .q    (buf_q)
    );

    assign load.load_ready = ~buf_full;
    assign accept          = load.load_valid & ~buf_full;

    // Move the next bit toward the output end, filling the vacated end with 0.
    generate
        if (MSB_FIRST) begin : g_msb
            assign shreg_adv = {shreg_q[WIDTH-2:0], 1'b0};
        end else begin : g_lsb
            assign shreg_adv = {1'b0, shreg_q[WIDTH-1:1]};
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        buf_wr  = 1'b0;
        buf_rd  = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    shreg_d = load.load_data;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                // Last bit retiring: chain the buffered word, then a same-edge word, else stop.
                if (en && (cnt_q == LAST)) begin
                    done_d = 1'b1;
                    cnt_d  = '0;
                    if (buf_full) begin
                        shreg_d = buf_q;
                        buf_rd  = 1'b1;
                    end else if (accept) begin
                        shreg_d = load.load_data;
                    end else begin
                        shreg_d = '0;
                        state_d = IDLE;
                    end
                end else begin
                    buf_wr = accept;
                    if (en) begin
                        shreg_d = shreg_adv;
                        cnt_d   = cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign frame    = (state_q == SHIFT);
    assign sout     = frame & (MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0]);
    assign sout_bar = ~sout;
    assign done     = done_q;

endmodule

// File: tb/tb_shift_serializer_tx.sv
// Bench for shift_serializer_tx: an MSB-first and an LSB-first instance share clock, reset and en,
// checked against fixed vector tables, directed sequences and a word/bit-index reference model.
module tb_shift_serializer_tx;
    import shift_pkg::*;

    localparam int W = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic en  = 1'b0;

    always #5 clk = ~clk;

    shift_serializer_tx_if #(.WIDTH(W)) bus_m ();
    shift_serializer_tx_if #(.WIDTH(W)) bus_l ();

    logic sout_m, sout_bar_m, frame_m, done_m;
    logic sout_l, sout_bar_l, frame_l, done_l;

    shift_serializer_tx #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .load     (bus_m),
        .sout     (sout_m),
        .sout_bar (sout_bar_m),
        .frame    (frame_m),
        .done     (done_m)
    );

    shift_serializer_tx #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .load     (bus_l),
        .sout     (sout_l),
        .sout_bar (sout_bar_l),
        .frame    (frame_l),
        .done     (done_l)
    );

    // Reference view: a word being sent, the index of the bit on the line, and one waiting word.
    typedef struct {
        bit           active;
        int           idx;
        logic [W-1:0] cur;
        bit           pend_full;
        logic [W-1:0] pend;
        bit           done;
    } model_t;

    typedef struct {
        int           dut;
        bit           v;
        logic [W-1:0] d;
        bit           e;
        bit           sout;
        bit           frame;
        bit           done;
        bit           ready;
    } vec_t;

    model_t mdl [2];
    vec_t   vecs[$];
    int     checks = 0;
    int     errors = 0;

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            mdl[k].active    = 1'b0;
            mdl[k].idx       = 0;
            mdl[k].cur       = '0;
            mdl[k].pend_full = 1'b0;
            mdl[k].pend      = '0;
            mdl[k].done      = 1'b0;
        end
    endtask

    task automatic model_step(input int k, input bit v, input logic [W-1:0] d, input bit e);
        bit acc;
        acc = v && !mdl[k].pend_full;
        mdl[k].done = 1'b0;
        if (!mdl[k].active) begin
            if (acc) begin
                mdl[k].cur    = d;
                mdl[k].idx    = 0;
                mdl[k].active = 1'b1;
            end
        end else if (e && mdl[k].idx == W - 1) begin
            mdl[k].done = 1'b1;
            if (mdl[k].pend_full) begin
                mdl[k].cur       = mdl[k].pend;
                mdl[k].pend_full = 1'b0;
                mdl[k].idx       = 0;
            end else if (acc) begin
                mdl[k].cur = d;
                mdl[k].idx = 0;
            end else begin
                mdl[k].active = 1'b0;
            end
        end else begin
            if (acc) begin
                mdl[k].pend_full = 1'b1;
                mdl[k].pend      = d;
            end
            if (e) mdl[k].idx++;
        end
    endtask

    function automatic bit model_sout(input int k);
        if (!mdl[k].active) return 1'b0;
        return (k == 0) ? mdl[k].cur[W-1-mdl[k].idx] : mdl[k].cur[mdl[k].idx];
    endfunction

    task automatic check_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    task automatic check_output(input string tag);
        check_bit({tag, " msb sout"},     sout_m,           model_sout(0));
        check_bit({tag, " msb sout_bar"}, sout_bar_m,       ~model_sout(0));
        check_bit({tag, " msb frame"},    frame_m,          mdl[0].active);
        check_bit({tag, " msb done"},     done_m,           mdl[0].done);
        check_bit({tag, " msb ready"},    bus_m.load_ready, !mdl[0].pend_full);
        check_bit({tag, " lsb sout"},     sout_l,           model_sout(1));
        check_bit({tag, " lsb sout_bar"}, sout_bar_l,       ~model_sout(1));
        check_bit({tag, " lsb frame"},    frame_l,          mdl[1].active);
        check_bit({tag, " lsb done"},     done_l,           mdl[1].done);
        check_bit({tag, " lsb ready"},    bus_l.load_ready, !mdl[1].pend_full);
    endtask

    // Called at a falling edge: drive, take one rising edge, then check at the next falling edge.
    task automatic apply_stimulus(input string tag,
                                  input bit v0, input logic [W-1:0] d0,
                                  input bit v1, input logic [W-1:0] d1,
                                  input bit e);
        bus_m.load_valid = v0;
        bus_m.load_data  = d0;
        bus_l.load_valid = v1;
        bus_l.load_data  = d1;
        en               = e;
        @(posedge clk);
        model_step(0, v0, d0, e);
        model_step(1, v1, d1, e);
        @(negedge clk);
        bus_m.load_valid = 1'b0;
        bus_l.load_valid = 1'b0;
        bus_m.load_data  = W'($urandom);
        bus_l.load_data  = W'($urandom);
        check_output(tag);
    endtask

    task automatic send_m(input string tag, input bit v, input logic [W-1:0] d, input bit e);
        apply_stimulus(tag, v, d, 1'b0, '0, e);
    endtask

    task automatic add_vec(input int dut, input bit v, input logic [W-1:0] d, input bit e,
                           input bit s, input bit f, input bit dn, input bit r);
        vec_t x;
        x.dut = dut; x.v = v; x.d = d; x.e = e;
        x.sout = s; x.frame = f; x.done = dn; x.ready = r;
        vecs.push_back(x);
    endtask

    initial begin
        bus_m.load_valid = 1'b0;
        bus_m.load_data  = '0;
        bus_l.load_valid = 1'b0;
        bus_l.load_data  = '0;
        model_reset();

        // 0xA5 MSB first, then 0x01 LSB first, en held high.
        add_vec(0, 1, 8'hA5, 1, 1, 1, 0, 1);
        add_vec(0, 0, 8'h00, 1, 0, 1, 0, 1);
        add_vec(0, 0, 8'h00, 1, 1, 1, 0, 1);
        add_vec(0, 0, 8'h00, 1, 0, 1, 0, 1);
        add_vec(0, 0, 8'h00, 1, 0, 1, 0, 1);
        add_vec(0, 0, 8'h00, 1, 1, 1, 0, 1);
        add_vec(0, 0, 8'h00, 1, 0, 1, 0, 1);
        add_vec(0, 0, 8'h00, 1, 1, 1, 0, 1);
        add_vec(0, 0, 8'h00, 1, 0, 0, 1, 1);
        add_vec(0, 0, 8'h00, 1, 0, 0, 0, 1);
        add_vec(1, 1, 8'h01, 1, 1, 1, 0, 1);
        for (int i = 0; i < 7; i++) add_vec(1, 0, 8'h00, 1, 0, 1, 0, 1);
        add_vec(1, 0, 8'h00, 1, 0, 0, 1, 1);
        add_vec(1, 0, 8'h00, 1, 0, 0, 0, 1);

        #12;
        check_output("reset");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        foreach (vecs[i]) begin
            if (vecs[i].dut == 0) begin
                apply_stimulus("table", vecs[i].v, vecs[i].d, 1'b0, '0, vecs[i].e);
                check_bit("table sout",  sout_m,           vecs[i].sout);
                check_bit("table frame", frame_m,          vecs[i].frame);
                check_bit("table done",  done_m,           vecs[i].done);
                check_bit("table ready", bus_m.load_ready, vecs[i].ready);
            end else begin
                apply_stimulus("table", 1'b0, '0, vecs[i].v, vecs[i].d, vecs[i].e);
                check_bit("table sout",  sout_l,           vecs[i].sout);
                check_bit("table frame", frame_l,          vecs[i].frame);
                check_bit("table done",  done_l,           vecs[i].done);
                check_bit("table ready", bus_l.load_ready, vecs[i].ready);
            end
        end

        // Back-to-back: 0xA5 then 0x3C two cycles later.
        send_m("b2b", 1, 8'hA5, 1);
        send_m("b2b", 0, 8'h00, 1);
        send_m("b2b", 1, 8'h3C, 1);
        check_bit("b2b ready low", bus_m.load_ready, 1'b0);
        for (int i = 0; i < 20; i++) send_m("b2b", 0, 8'h00, 1);

        // Slow ticks: en on every third edge.
        send_m("slow", 1, 8'hF0, 0);
        for (int i = 0; i < 30; i++) send_m("slow", 0, 8'h00, (i % 3) == 2);

        // New word offered exactly on the edge retiring the last bit of 0x81.
        send_m("bypass", 1, 8'h81, 1);
        for (int i = 0; i < 7; i++) send_m("bypass", 0, 8'h00, 1);
        send_m("bypass", 1, 8'h42, 1);
        check_bit("bypass frame", frame_m, 1'b1);
        check_bit("bypass first bit", sout_m, 1'b0);
        for (int i = 0; i < 10; i++) send_m("bypass", 0, 8'h00, 1);

        // Asynchronous reset mid-frame, then a fresh word.
        send_m("rstmid", 1, 8'hFF, 1);
        send_m("rstmid", 1, 8'h55, 1);
        send_m("rstmid", 0, 8'h00, 1);
        rst = 1'b0;
        #1;
        check_bit("rstmid sout",     sout_m,           1'b0);
        check_bit("rstmid sout_bar", sout_bar_m,       1'b1);
        check_bit("rstmid frame",    frame_m,          1'b0);
        check_bit("rstmid done",     done_m,           1'b0);
        check_bit("rstmid ready",    bus_m.load_ready, 1'b1);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        check_output("rstmid idle");
        send_m("after rst", 1, 8'h01, 1);
        for (int i = 0; i < 10; i++) send_m("after rst", 0, 8'h00, 1);

        // Random traffic on both instances against the reference model.
        for (int i = 0; i < 400; i++) begin
            apply_stimulus("random",
                           ($urandom_range(0, 9) < 4), W'($urandom),
                           ($urandom_range(0, 9) < 4), W'($urandom),
                           ($urandom_range(0, 9) < 6));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
